// File: rtl/map_pkg.sv
// Shared mapper definitions: save-state bus and MMC3 IRQ register decode values.
package map_pkg;

    typedef struct packed {
        logic       act;
        logic       we_reg;
        logic [7:0] addr;
        logic [7:0] dato;
    } SSTBus;

    // reg_addr is {A15, A14, A13, A0}
    localparam logic [3:0] MMC3_REG_IRQ_LATCH  = 4'hC;
    localparam logic [3:0] MMC3_REG_IRQ_RELOAD = 4'hD;
    localparam logic [3:0] MMC3_REG_IRQ_DIS    = 4'hE;
    localparam logic [3:0] MMC3_REG_IRQ_EN     = 4'hF;

endpackage

// File: rtl/mmc3_a12_filter.sv
// PPU A12 rise filter: a rise only clocks the counter after A12 has been low
// for A12_LOW_M2 falling edges of M2.
module mmc3_a12_filter #(
    parameter int A12_LOW_M2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_m2,
    input  logic       ppu_a12,
    input  logic       freeze,
    input  logic       ld_en,
    input  logic [1:0] ld_val,
    output logic       a12_clk,
    output logic [1:0] low_cnt
);

    localparam logic [1:0] LOW_MAX = 2'(A12_LOW_M2);

    logic       m2_d_q, m2_d_d;
    logic       a12_d_q, a12_d_d;
    logic [1:0] low_cnt_q, low_cnt_d;

    always_comb begin
        m2_d_d    = cpu_m2;
        a12_d_d   = ppu_a12;
        low_cnt_d = low_cnt_q;
        a12_clk   = 1'b0;
        // Edge history keeps tracking while frozen so release does not fake an edge.
        if (ld_en) begin
            low_cnt_d = ld_val;
        end else if (!freeze) begin
            if (ppu_a12) begin
                low_cnt_d = '0;
            end else if (m2_d_q && !cpu_m2 && (low_cnt_q < LOW_MAX)) begin
                low_cnt_d = low_cnt_q + 2'd1;
            end
            a12_clk = !rst && !a12_d_q && ppu_a12 && (low_cnt_q == LOW_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m2_d_q    <= 1'b0;
            a12_d_q   <= 1'b0;
            low_cnt_q <= '0;
        end else begin
            m2_d_q    <= m2_d_d;
            a12_d_q   <= a12_d_d;
            low_cnt_q <= low_cnt_d;
        end
    end

    assign low_cnt = low_cnt_q;

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ: reload/decrement counter clocked by filtered A12 rises,
// $C000-$E001 register handling and save-state access.
module mmc3_scanline_irq
    import map_pkg::*;
#(
    parameter int A12_LOW_M2 = 3,
    parameter int SST_BASE   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       decode_en,
    input  logic       cpu_m2,
    input  logic [7:0] cpu_data,
    input  logic [3:0] reg_addr,
    input  logic       ppu_a12,
    input  logic       mmc3a,
    input  SSTBus      sst,
    output logic       irq,
    output logic       a12_clk,
    output logic [7:0] sst_di
);

    localparam logic [7:0] SST_LATCH = 8'(SST_BASE);
    localparam logic [7:0] SST_CNT   = 8'(SST_BASE + 1);
    localparam logic [7:0] SST_FLAGS = 8'(SST_BASE + 2);
    localparam logic [7:0] SST_LOW   = 8'(SST_BASE + 3);

    logic [7:0] latch_q, latch_d;
    logic [7:0] counter_q, counter_d;
    logic       reload_q, reload_d;
    logic       irq_en_q, irq_en_d;
    logic       irq_q, irq_d;
    logic [7:0] cnt_next;
    logic       irq_set;
    logic       wr_en;
    logic       sst_wr;
    logic [1:0] low_cnt;

    assign wr_en  = decode_en && !sst.act;
    assign sst_wr = sst.act && sst.we_reg;

    mmc3_a12_filter #(
        .A12_LOW_M2(A12_LOW_M2)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .cpu_m2  (cpu_m2),
        .ppu_a12 (ppu_a12),
        .freeze  (sst.act),
        .ld_en   (sst_wr && (sst.addr == SST_LOW)),
        .ld_val  (sst.dato[1:0]),
        .a12_clk (a12_clk),
        .low_cnt (low_cnt)
    );

    always_comb begin
        cnt_next = ((counter_q == 8'd0) || reload_q) ? latch_q : counter_q - 8'd1;
        // MMC3A only fires when the zero was reached by counting or a forced reload.
        irq_set  = (cnt_next == 8'd0) && irq_en_q &&
                   (!mmc3a || (counter_q != 8'd0) || reload_q);
    end

    always_comb begin
        latch_d   = latch_q;
        counter_d = counter_q;
        reload_d  = reload_q;
        irq_en_d  = irq_en_q;
        irq_d     = irq_q;
        if (a12_clk) begin
            counter_d = cnt_next;
            reload_d  = 1'b0;
            if (irq_set) irq_d = 1'b1;
        end
        // Register writes come after the step so they win same-clk collisions.
        if (wr_en) begin
            case (reg_addr)
                MMC3_REG_IRQ_LATCH:  latch_d = cpu_data;
                MMC3_REG_IRQ_RELOAD: reload_d = 1'b1;
                MMC3_REG_IRQ_DIS: begin
                    irq_en_d = 1'b0;
                    irq_d    = 1'b0;
                end
                MMC3_REG_IRQ_EN:     irq_en_d = 1'b1;
                default: ;
            endcase
        end
        if (sst_wr) begin
            case (sst.addr)
                SST_LATCH: latch_d = sst.dato;
                SST_CNT:   counter_d = sst.dato;
                SST_FLAGS: begin
                    reload_d = sst.dato[2];
                    irq_en_d = sst.dato[1];
                    irq_d    = sst.dato[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q   <= '0;
            counter_q <= '0;
            reload_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            latch_q   <= latch_d;
            counter_q <= counter_d;
            reload_q  <= reload_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        case (sst.addr)
            SST_LATCH: sst_di = latch_q;
            SST_CNT:   sst_di = counter_q;
            SST_FLAGS: sst_di = {5'b0, reload_q, irq_en_q, irq_q};
            SST_LOW:   sst_di = {6'b0, low_cnt};
            default:   sst_di = 8'hFF;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Bench for mmc3_scanline_irq: directed scenarios plus a randomized run,
// all checked against a behavioural model of the IRQ unit.
module tb_mmc3_scanline_irq;
    import map_pkg::*;

    localparam int A12_LOW_M2 = 3;
    localparam int SST_BASE   = 16;

    logic       clk = 1'b0;
    logic       rst, decode_en, cpu_m2, ppu_a12, mmc3a;
    logic [7:0] cpu_data;
    logic [3:0] reg_addr;
    SSTBus      sst;
    logic       irq, a12_clk;
    logic [7:0] sst_di;

    int n_vec = 0;
    int n_err = 0;

    // Model state: m_falls counts M2 falls since A12 last went low (unbounded).
    int m_latch = 0, m_counter = 0, m_falls = 0;
    bit m_reload = 0, m_en = 0, m_irq = 0, m_pm2 = 0, m_pa12 = 0;

    mmc3_scanline_irq #(.A12_LOW_M2(A12_LOW_M2), .SST_BASE(SST_BASE)) dut (
        .clk(clk), .rst(rst), .decode_en(decode_en), .cpu_m2(cpu_m2),
        .cpu_data(cpu_data), .reg_addr(reg_addr), .ppu_a12(ppu_a12),
        .mmc3a(mmc3a), .sst(sst), .irq(irq), .a12_clk(a12_clk), .sst_di(sst_di)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int off;
        off = int'(a) - SST_BASE;
        case (off)
            0: return 8'(m_latch);
            1: return 8'(m_counter);
            2: return {5'b0, m_reload, m_en, m_irq};
            3: return 8'((m_falls > A12_LOW_M2) ? A12_LOW_M2 : m_falls);
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: check the strobe mid-cycle, advance the model, check state after the edge.
    task automatic tick();
        bit rise, fall, exp_clk;
        int nxt, off;
        @(negedge clk);
        rise    = !m_pa12 && ppu_a12;
        fall    = m_pm2 && !cpu_m2;
        exp_clk = !rst && !sst.act && rise && (m_falls >= A12_LOW_M2);
        chk("a12_clk", {7'b0, a12_clk}, {7'b0, exp_clk});
        if (rst) begin
            m_latch = 0; m_counter = 0; m_falls = 0;
            m_reload = 0; m_en = 0; m_irq = 0; m_pm2 = 0; m_pa12 = 0;
        end else begin
            m_pm2  = cpu_m2;
            m_pa12 = ppu_a12;
            if (!sst.act) begin
                if (ppu_a12) m_falls = 0;
                else if (fall) m_falls++;
                if (exp_clk) begin
                    nxt = (m_counter == 0 || m_reload) ? m_latch : m_counter - 1;
                    if (nxt == 0 && m_en && (!mmc3a || m_counter != 0 || m_reload)) m_irq = 1;
                    m_counter = nxt;
                    m_reload  = 0;
                end
                if (decode_en) begin
                    case (reg_addr)
                        4'hC: m_latch = cpu_data;
                        4'hD: m_reload = 1;
                        4'hE: begin m_en = 0; m_irq = 0; end
                        4'hF: m_en = 1;
                        default: ;
                    endcase
                end
            end else if (sst.we_reg) begin
                off = int'(sst.addr) - SST_BASE;
                case (off)
                    0: m_latch = sst.dato;
                    1: m_counter = sst.dato;
                    2: begin m_reload = sst.dato[2]; m_en = sst.dato[1]; m_irq = sst.dato[0]; end
                    3: m_falls = sst.dato[1:0];
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
        chk("sst_di", sst_di, m_read(sst.addr));
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        decode_en = 1'b1; reg_addr = a; cpu_data = d;
        tick();
        decode_en = 1'b0;
    endtask

    task automatic m2_falls(input int n);
        repeat (n) begin
            cpu_m2 = 1'b1; tick();
            cpu_m2 = 1'b0; tick();
        end
    endtask

    task automatic rise();
        ppu_a12 = 1'b1; tick();
        ppu_a12 = 1'b0; tick();
    endtask

    task automatic filt_rise();
        m2_falls(3);
        rise();
    endtask

    task automatic peek(input int off, output logic [7:0] v);
        sst.addr = 8'(SST_BASE + off);
        #1;
        v = sst_di;
    endtask

    task automatic sst_wr(input int off, input logic [7:0] d);
        sst.act = 1'b1; sst.we_reg = 1'b1; sst.addr = 8'(SST_BASE + off); sst.dato = d;
        tick();
        sst.act = 1'b0; sst.we_reg = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; decode_en = 1'b0; cpu_m2 = 1'b0; ppu_a12 = 1'b0; mmc3a = 1'b0;
        cpu_data = '0; reg_addr = '0; sst = '0; sst.addr = 8'(SST_BASE + 1);
        tick(); tick();
        rst = 1'b0;
        chk("reset_irq", {7'b0, irq}, 8'h00);
        peek(1, v); chk("reset_counter", v, 8'h00);
        peek(2, v); chk("reset_flags", v, 8'h00);

        // Basic count 3,2,1,0 then acknowledge
        wr(4'hC, 8'd3); wr(4'hD, 8'd0); wr(4'hF, 8'd0);
        for (int i = 0; i < 4; i++) begin
            filt_rise();
            peek(1, v); chk("basic_counter", v, 8'(3 - i));
        end
        chk("basic_irq", {7'b0, irq}, 8'h01);
        wr(4'hE, 8'd0);
        chk("basic_ack", {7'b0, irq}, 8'h00);

        // Short low periods are filtered out
        m2_falls(1); rise();
        m2_falls(2); rise();
        peek(1, v); chk("filter_hold", v, 8'h00);
        m2_falls(3); rise();
        peek(1, v); chk("filter_pass", v, 8'h03);

        // Latch = 0, new behaviour: IRQ on every rise
        wr(4'hC, 8'd0); wr(4'hD, 8'd0); wr(4'hF, 8'd0);
        for (int i = 0; i < 3; i++) begin
            filt_rise();
            chk("zero_new_irq", {7'b0, irq}, 8'h01);
            wr(4'hE, 8'd0); wr(4'hF, 8'd0);
        end
        // Latch = 0, old behaviour: one IRQ after the reload only
        mmc3a = 1'b1;
        wr(4'hD, 8'd0);
        filt_rise();
        chk("zero_old_first", {7'b0, irq}, 8'h01);
        wr(4'hE, 8'd0); wr(4'hF, 8'd0);
        for (int i = 0; i < 2; i++) begin
            filt_rise();
            chk("zero_old_none", {7'b0, irq}, 8'h00);
        end
        mmc3a = 1'b0;

        // Acknowledge collides with the IRQ-setting step
        wr(4'hC, 8'd2); wr(4'hD, 8'd0);
        filt_rise(); filt_rise();
        m2_falls(3);
        ppu_a12 = 1'b1; decode_en = 1'b1; reg_addr = 4'hE;
        tick();
        decode_en = 1'b0; ppu_a12 = 1'b0;
        tick();
        chk("ack_collide_irq", {7'b0, irq}, 8'h00);
        peek(1, v); chk("ack_collide_cnt", v, 8'h00);

        // Reload request collides with a step at counter 5
        wr(4'hC, 8'd6); wr(4'hD, 8'd0);
        filt_rise(); filt_rise();
        m2_falls(3);
        ppu_a12 = 1'b1; decode_en = 1'b1; reg_addr = 4'hD;
        tick();
        decode_en = 1'b0; ppu_a12 = 1'b0;
        tick();
        peek(1, v); chk("reload_collide_cnt", v, 8'h04);
        peek(2, v); chk("reload_collide_flag", {7'b0, v[2]}, 8'h01);
        filt_rise();
        peek(1, v); chk("reload_collide_load", v, 8'h06);

        // Save-state load and resume
        sst_wr(1, 8'h42); sst_wr(0, 8'h10); sst_wr(2, 8'h01);
        peek(0, v); chk("sst_latch", v, 8'h10);
        peek(1, v); chk("sst_counter", v, 8'h42);
        peek(2, v); chk("sst_flags", v, 8'h01);
        peek(5, v); chk("sst_unmapped", v, 8'hFF);
        sst.addr = 8'(SST_BASE + 1);
        filt_rise();
        peek(1, v); chk("sst_resume_cnt", v, 8'h41);
        chk("sst_resume_irq", {7'b0, irq}, 8'h01);

        // Reset mid-operation
        sst_wr(1, 8'h07); sst_wr(2, 8'h03);
        m2_falls(3);
        rst = 1'b1; ppu_a12 = 1'b1;
        tick();
        rst = 1'b0; ppu_a12 = 1'b0;
        chk("rst_irq", {7'b0, irq}, 8'h00);
        peek(1, v); chk("rst_counter", v, 8'h00);
        peek(3, v); chk("rst_low_cnt", v, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            decode_en = ($urandom_range(0, 9) == 0);
            reg_addr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(12, 15));
            cpu_data  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3))
                                                    : 8'($urandom_range(0, 255));
            cpu_m2    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) ppu_a12 = ~ppu_a12;
            if ($urandom_range(0, 99) == 0) mmc3a = ~mmc3a;
            sst.act    = ($urandom_range(0, 24) == 0);
            sst.we_reg = ($urandom_range(0, 1) == 1);
            sst.addr   = 8'(SST_BASE + $urandom_range(0, 4));
            sst.dato   = 8'($urandom_range(0, 255));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmc3_scanline_irq.md
Name: mmc3_scanline_irq

Overview:
- Scanline IRQ unit for MMC3-family mapper cores (198, 004 and their subs). It sits directly downstream of the mapper register decode and drives the irq_pend input of the mapper chip.
- Filters PPU A12 rising edges using M2 timing, runs the 8-bit reload/decrement counter, and raises the IRQ line.
- Handles the $C000-$E001 register writes and exposes its state on the save-state bus.

Parameters:
- A12_LOW_M2, 3, number of M2 falling edges with A12 low required before an A12 rise counts as a clock.
- SST_BASE, 16, first save-state register index owned by this block.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- decode_en  in  1  CPU write qualifier (cpu_m3 & !cpu_rw), level.
- cpu_m2  in  1  CPU M2, sampled in clk domain.
- cpu_data  in  8  CPU write data.
- reg_addr  in  4  {A15, A14, A13, A0}.
- ppu_a12  in  1  PPU address bit 12, clk domain.
- mmc3a  in  1  1 = MMC3A/old IRQ behaviour; 0 = MMC3B/C (new).
- sst  in  SSTBus  save-state bus (act, we_reg, addr, dato).
- irq  out  1  IRQ pending, active-high.
- a12_clk  out  1  one-clk strobe per accepted A12 rise (observability).
- sst_di  out  8  save-state read data.

Behaviour:
- Reset: latch=0, counter=0, reload_flag=0, irq_en=0, irq=0, low_cnt=0, a12_clk=0, edge history regs=0.
- Register writes: when decode_en=1 and sst.act=0. Writes are level-applied; every write is idempotent while decode_en is held.
  - 0xC: latch <= cpu_data.
  - 0xD: reload_flag <= 1. The counter itself is not touched.
  - 0xE: irq_en <= 0 and irq <= 0 (acknowledge).
  - 0xF: irq_en <= 1. A pending irq is not cleared.
- M2 falling edge: m2_d is cpu_m2 delayed one clk. A falling edge is detected when m2_d=1 and cpu_m2=0.
- A12 low counter: low_cnt, 2 bits, saturating at A12_LOW_M2.
  - While ppu_a12=0, low_cnt increments on each M2 falling edge.
  - While ppu_a12=1, low_cnt <= 0.
- A12 rise: a12_d=0 and ppu_a12=1.
  - If low_cnt == A12_LOW_M2 at the rise, a12_clk=1 for exactly that clk.
  - Otherwise the rise is ignored; this suppresses the sprite-fetch triple toggles.
- Counter step on a12_clk:
  - If counter==0 or reload_flag=1: counter <= latch and reload_flag <= 0.
  - Otherwise counter <= counter-1.
  - next is the value written to counter.
- IRQ set (same clk as the counter step):
  - mmc3a=0: irq <= 1 if next==0 and irq_en=1.
  - mmc3a=1: irq <= 1 if next==0, irq_en=1, and (previous counter!=0 or reload_flag was 1).
- Simultaneous events in one clk:
  - A 0xD write together with a12_clk: the step uses the old reload_flag, then reload_flag ends at 1.
  - A 0xE write together with an IRQ set: 0xE wins (irq=0).
  - A 0xC write together with a12_clk: the reload uses the old latch.
- Wrap-around: latch=0 with irq_en=1 and mmc3a=0 gives an IRQ on every accepted A12 rise. With mmc3a=1 it gives only one IRQ after the reload flag is set.
- Save state, only while sst.act=1:
  - When sst.act=1, all normal register updates and counter steps are frozen.
  - Write when sst.we_reg=1 and cpu_m3-qualified decode is not required.
  - SST_BASE+0 = latch.
  - SST_BASE+1 = counter.
  - SST_BASE+2 = {5'b0, reload_flag, irq_en, irq}.
  - SST_BASE+3 = {6'b0, low_cnt}.
  - sst_di is combinational: the selected register for these four addresses, 8'hFF otherwise.
- Reset taken mid-count clears all state in the next clk and overrides sst writes.
- Latency: irq asserts 1 clk after the A12 rise clk is sampled. It deasserts in the clk after the 0xE write.

Decomposition:
- Shared package (map_pkg), existing: SSTBus typedef.
- New constants in map_pkg: MMC3_REG_IRQ_LATCH=4'hC, MMC3_REG_IRQ_RELOAD=4'hD, MMC3_REG_IRQ_DIS=4'hE, MMC3_REG_IRQ_EN=4'hF.
- One sub-module is natural: mmc3_a12_filter. It takes clk, rst, cpu_m2, ppu_a12 and outputs a12_clk plus low_cnt for save state.
- Counter and register logic stay in the top module.

Test Plan:
- Basic count: write latch=3, 0xD, 0xF; give 4 filtered A12 rises -> counter 3,2,1,0; irq=1 after the 4th rise; 0xE clears irq within 1 clk.
- Filter: A12 rises with only 1 or 2 M2 falls low between them -> a12_clk never pulses and counter is unchanged. With 3 falls -> a12_clk pulses once.
- Latch=0: mmc3a=0 -> irq on every rise after each 0xE ack. mmc3a=1 -> irq only on the first rise after 0xD, none afterwards.
- Collisions: 0xE write in the same clk as the rise reaching 0 -> irq stays 0. 0xD in the same clk as a rise at counter=5 -> counter=4 and reload_flag=1; the next rise loads the latch.
- Save state: load counter=0x42, latch=0x10, irq=1 via sst writes, release act -> sst_di reads back 0x10/0x42/0x01. The next rise gives counter 0x41 and irq stays 1.
- Reset mid-operation: rst asserted with irq=1 and counter=7 -> next clk all outputs 0 and sst_di at SST_BASE+1 reads 0x00.
